// File: rtl/seq_alu.sv
// Clocked signed ALU: single-cycle add/sub/saturating add, multi-cycle shift-add multiply.
// Results are registered and announced with a one-cycle done pulse.
module seq_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       opcode,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [1:0] OpAdd  = 2'b00;
    localparam logic [1:0] OpSub  = 2'b01;
    localparam logic [1:0] OpMul  = 2'b10;
    localparam logic [1:0] OpSadd = 2'b11;

    typedef enum logic [1:0] {StIdle, StMul, StFin} state_e;

    state_e               state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH:0]       mplier;
    logic [2*WIDTH-1:0]   acc;
    logic                 neg;

    logic [WIDTH-1:0]     sum, diff, sat;
    logic                 sum_ovf, diff_ovf;
    logic [WIDTH:0]       ext_a, ext_b, abs_a, abs_b;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH:0]       prod_hi;
    logic                 prod_ovf;

    always_comb begin
        sum      = data1 + data2;
        diff     = data1 - data2;
        sum_ovf  = (data1[WIDTH-1] == data2[WIDTH-1]) && (sum[WIDTH-1] != data1[WIDTH-1]);
        diff_ovf = (data1[WIDTH-1] != data2[WIDTH-1]) && (diff[WIDTH-1] != data1[WIDTH-1]);
        sat      = sum;
        if (sum_ovf) begin
            sat = data1[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        // One extra bit so |-2^(WIDTH-1)| is representable
        ext_a    = {data1[WIDTH-1], data1};
        ext_b    = {data2[WIDTH-1], data2};
        abs_a    = data1[WIDTH-1] ? -ext_a : ext_a;
        abs_b    = data2[WIDTH-1] ? -ext_b : ext_b;
        prod     = neg ? -acc : acc;
        // In range iff the top WIDTH+1 bits are a pure sign extension
        prod_hi  = prod[2*WIDTH-1:WIDTH-1];
        prod_ovf = !((&prod_hi) || (~|prod_hi));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= StIdle;
            cnt      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            neg      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        case (opcode)
                            OpAdd: begin
                                result   <= sum;
                                overflow <= sum_ovf;
                                done     <= 1'b1;
                            end
                            OpSub: begin
                                result   <= diff;
                                overflow <= diff_ovf;
                                done     <= 1'b1;
                            end
                            OpSadd: begin
                                result   <= sat;
                                overflow <= sum_ovf;
                                done     <= 1'b1;
                            end
                            OpMul: begin
                                mcand  <= {{(WIDTH-1){1'b0}}, abs_a};
                                mplier <= abs_b;
                                acc    <= '0;
                                neg    <= data1[WIDTH-1] ^ data2[WIDTH-1];
                                cnt    <= CW'(WIDTH);
                                busy   <= 1'b1;
                                state  <= StMul;
                            end
                            default: ;
                        endcase
                    end
                end
                StMul: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= StFin;
                    end
                end
                StFin: begin
                    result   <= prod[WIDTH-1:0];
                    overflow <= prod_ovf;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=8 and WIDTH=16; a scoreboard queue per instance
// holds expected results, popped whenever the instance pulses done.
module tb_seq_alu;

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, SADD = 2'b11;

    typedef struct packed {
        logic        ovf;
        logic [15:0] res;
    } exp_t;

    logic        clk, rst_n;
    logic        start8, busy8, done8, ovf8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, res8;
    logic        start16, busy16, done16, ovf16;
    logic [1:0]  op16;
    logic [15:0] a16, b16, res16;

    exp_t q8[$], q16[$];
    exp_t e8, e16;
    int   checks = 0, errors = 0;
    int   pushed8 = 0, pushed16 = 0, seen8 = 0, seen16 = 0;

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(rst_n), .start(start8), .opcode(op8), .data1(a8), .data2(b8),
        .busy(busy8), .done(done8), .result(res8), .overflow(ovf8)
    );

    seq_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .reset_n(rst_n), .start(start16), .opcode(op16), .data1(a16), .data2(b16),
        .busy(busy16), .done(done16), .result(res16), .overflow(ovf16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done8) begin
            seen8++;
            chk("done8_with_busy", {31'd0, busy8}, 32'd0);
            chk("done8_expected", {31'd0, q8.size() != 0}, 32'd1);
            if (q8.size() != 0) begin
                e8 = q8.pop_front();
                chk("result8", {23'd0, ovf8, res8}, {23'd0, e8.ovf, e8.res[7:0]});
            end
        end
        if (done16) begin
            seen16++;
            chk("done16_with_busy", {31'd0, busy16}, 32'd0);
            chk("done16_expected", {31'd0, q16.size() != 0}, 32'd1);
            if (q16.size() != 0) begin
                e16 = q16.pop_front();
                chk("result16", {15'd0, ovf16, res16}, {15'd0, e16.ovf, e16.res});
            end
        end
    end

    // Called at a negedge; returns at the next negedge with start dropped.
    task automatic go8(input logic [1:0] op, input int a, input int b, input bit push,
                       input int er, input bit eo);
        exp_t x;
        start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        if (push) begin
            x.ovf = eo; x.res = er[15:0];
            q8.push_back(x);
            pushed8++;
        end
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic go16(input logic [1:0] op, input int a, input int b, input int er,
                        input bit eo);
        exp_t x;
        start16 = 1'b1; op16 = op; a16 = a[15:0]; b16 = b[15:0];
        x.ovf = eo; x.res = er[15:0];
        q16.push_back(x);
        pushed16++;
        @(negedge clk);
        start16 = 1'b0;
    endtask

    task automatic wait_q8(input string tag);
        int n = 0;
        while (q8.size() != 0 && n < 40) begin
            @(posedge clk); #2; n++;
        end
        chk(tag, q8.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_q16(input string tag);
        int n = 0;
        while (q16.size() != 0 && n < 40) begin
            @(posedge clk); #2; n++;
        end
        chk(tag, q16.size(), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        clk = 1'b0; rst_n = 1'b0;
        start8 = 1'b0; op8 = ADD; a8 = '0; b8 = '0;
        start16 = 1'b0; op16 = ADD; a16 = '0; b16 = '0;
        #12;
        chk("reset8", {21'd0, busy8, done8, ovf8, res8}, 32'd0);
        chk("reset16", {13'd0, busy16, done16, ovf16, res16}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back single-cycle ops
        go8(ADD, 25, 3, 1, 28, 0);
        chk("add_done_next_cycle", {31'd0, done8}, 32'd1);
        go8(ADD, 1, 8, 1, 9, 0);
        go8(ADD, 2, -5, 1, -3, 0);
        go8(ADD, 100, 50, 1, -106, 1);
        go8(SADD, 100, 50, 1, 127, 1);
        go8(SADD, -100, -50, 1, -128, 1);
        go8(SUB, -128, 1, 1, 127, 1);
        go8(SUB, 5, 7, 1, -2, 0);
        go8(SADD, 10, 20, 1, 30, 0);
        wait_q8("single_cycle_drain");

        // MUL latency/busy window with an ignored START mid-flight
        go8(MUL, 6, -2, 1, -12, 0);
        for (int i = 0; i < 9; i++) begin
            chk("mul_busy_window", {31'd0, busy8}, 32'd1);
            if (i == 3) begin
                start8 = 1'b1; op8 = ADD; a8 = 8'd1; b8 = 8'd1;
            end
            if (i == 4) start8 = 1'b0;
            @(negedge clk);
        end
        chk("mul_busy_cleared", {31'd0, busy8}, 32'd0);
        chk("mul_done_at_t0_plus_9", {31'd0, done8}, 32'd1);
        @(negedge clk);
        chk("no_extra_done", {31'd0, done8}, 32'd0);

        go8(MUL, -128, -1, 1, -128, 1);
        wait_q8("mul_min_neg1");
        go8(MUL, 0, -77, 1, 0, 0);
        wait_q8("mul_zero");
        go8(MUL, -128, 1, 1, -128, 0);
        wait_q8("mul_min_pos1");

        // Reset 4 edges into a MUL discards it
        go8(MUL, 7, 7, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("busy_before_reset", {31'd0, busy8}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("outputs_cleared_by_reset", {21'd0, busy8, done8, ovf8, res8}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_after_reset", {31'd0, busy8}, 32'd0);
        go8(MUL, 7, 7, 1, 49, 0);
        wait_q8("mul_after_reset");

        // WIDTH=16 instance
        go16(MUL, 300, -200, -60000, 1);
        n = 0;
        while (busy16 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("mul16_busy_cycles", n, 32'd17);
        chk("mul16_done", {31'd0, done16}, 32'd1);
        @(negedge clk);
        go16(ADD, 32767, 1, -32768, 1);
        wait_q16("add16");

        chk("done8_count", seen8, pushed8);
        chk("done16_count", seen16, pushed16);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
